// File: rtl/mlp_pkg.sv
// Shared constants for the M/N/K embedding MLP classifier tail: class count, index width,
// arg-max FSM encoding and beat-count helper.
package mlp_pkg;

  localparam int unsigned NUM_CLASSES = 387;
  localparam int unsigned IDX_WIDTH   = 9;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StScan = 2'd1,
    StDone = 2'd2
  } argmax_state_e;

  function automatic int unsigned calc_nbeats(input int unsigned num, input int unsigned lanes);
    return (num + lanes - 1) / lanes;
  endfunction

  localparam int unsigned NBEATS = calc_nbeats(NUM_CLASSES, 4);

endpackage

// File: rtl/argmax_reduce.sv
// Combinational LANES-to-1 max-with-index tree; lanes past NUM_CLASSES are masked.
// Compare is two's-complement when ARGMAX_SIGNED_EN is defined, unsigned otherwise.
module argmax_reduce #(
  parameter int unsigned DATA_WIDTH  = 8,
  parameter int unsigned NUM_CLASSES = mlp_pkg::NUM_CLASSES,
  parameter int unsigned LANES       = 4,
  parameter int unsigned IDX_WIDTH   = mlp_pkg::IDX_WIDTH
) (
  input  logic [DATA_WIDTH*LANES-1:0] lanes_i,
  input  logic [IDX_WIDTH-1:0]        base_idx_i,
  input  logic [DATA_WIDTH-1:0]       run_max_i,
  output logic                        win_upd_o,
  output logic [IDX_WIDTH-1:0]        win_index_o,
  output logic [DATA_WIDTH-1:0]       win_value_o
);
  import mlp_pkg::*;

  localparam int unsigned Nodes = 2 * LANES - 1;
  localparam int unsigned IdxW1 = IDX_WIDTH + 1;

  function automatic logic score_gt(input logic [DATA_WIDTH-1:0] a,
                                    input logic [DATA_WIDTH-1:0] b);
`ifdef ARGMAX_SIGNED_EN
    return $signed(a) > $signed(b);
`else
    return a > b;
`endif
  endfunction

  // Heap layout: leaves at LANES-1.., node n has children 2n+1 (lower lanes) and 2n+2.
  logic [DATA_WIDTH-1:0] node_val [Nodes];
  logic [IDX_WIDTH-1:0]  node_idx [Nodes];
  logic                  node_vld [Nodes];
  logic [IdxW1-1:0]      lane_idx;

  always_comb begin
    for (int unsigned n = 0; n < Nodes; n++) begin
      node_val[n] = '0;
      node_idx[n] = '0;
      node_vld[n] = 1'b0;
    end
    lane_idx = '0;
    for (int unsigned l = 0; l < LANES; l++) begin
      lane_idx                = {1'b0, base_idx_i} + IdxW1'(l);
      node_val[LANES - 1 + l] = lanes_i[l*DATA_WIDTH +: DATA_WIDTH];
      node_idx[LANES - 1 + l] = lane_idx[IDX_WIDTH-1:0];
      node_vld[LANES - 1 + l] = lane_idx < IdxW1'(NUM_CLASSES);
    end
    // Right child wins only when strictly greater, so ties go to the lower lane.
    for (int n = int'(LANES) - 2; n >= 0; n--) begin
      if (node_vld[2*n+2] &&
          (!node_vld[2*n+1] || score_gt(node_val[2*n+2], node_val[2*n+1]))) begin
        node_val[n] = node_val[2*n+2];
        node_idx[n] = node_idx[2*n+2];
        node_vld[n] = 1'b1;
      end else begin
        node_val[n] = node_val[2*n+1];
        node_idx[n] = node_idx[2*n+1];
        node_vld[n] = node_vld[2*n+1];
      end
    end
  end

  assign win_value_o = node_val[0];
  assign win_index_o = node_idx[0];
  assign win_upd_o   = node_vld[0] && score_gt(node_val[0], run_max_i);

endmodule

// File: rtl/argmax_scan.sv
// Sequential arg-max over a captured score vector, LANES entries per clock.
// Define ARGMAX_SIGNED_EN for two's-complement scores (running max starts at most-negative).
module argmax_scan #(
  parameter int unsigned DATA_WIDTH  = 8,
  parameter int unsigned NUM_CLASSES = mlp_pkg::NUM_CLASSES,
  parameter int unsigned LANES       = 4,
  parameter int unsigned IDX_WIDTH   = mlp_pkg::IDX_WIDTH
) (
  input  logic                            clk_i,
  input  logic                            rst_ni,
  input  logic                            start_i,
  input  logic [DATA_WIDTH*NUM_CLASSES-1:0] scores_i,
  output logic                            busy_o,
  output logic                            done_o,
  output logic [IDX_WIDTH-1:0]            max_index_o,
  output logic [DATA_WIDTH-1:0]           max_value_o
);
  import mlp_pkg::*;

  localparam int unsigned Nbeats    = calc_nbeats(NUM_CLASSES, LANES);
  localparam int unsigned BeatW     = (Nbeats > 1) ? $clog2(Nbeats) : 1;
  localparam int unsigned LaneW     = DATA_WIDTH * LANES;
  localparam int unsigned SnapW     = LaneW * Nbeats;
  localparam int unsigned LaneShift = $clog2(LANES);

`ifdef ARGMAX_SIGNED_EN
  localparam logic [DATA_WIDTH-1:0] MaxInit = {1'b1, {(DATA_WIDTH-1){1'b0}}};
`else
  localparam logic [DATA_WIDTH-1:0] MaxInit = '0;
`endif

  argmax_state_e         state_q;
  logic [BeatW-1:0]      beat_q;
  logic [SnapW-1:0]      snap_q;
  logic [DATA_WIDTH-1:0] run_max_q;
  logic [IDX_WIDTH-1:0]  run_idx_q;
  logic                  busy_q;
  logic                  done_q;
  logic [IDX_WIDTH-1:0]  max_index_q;
  logic [DATA_WIDTH-1:0] max_value_q;

  logic [IDX_WIDTH-1:0]  base_idx;
  logic                  win_upd;
  logic [IDX_WIDTH-1:0]  win_index;
  logic [DATA_WIDTH-1:0] win_value;

  assign base_idx = IDX_WIDTH'(beat_q) << LaneShift;

  // The snapshot shifts down one beat per cycle, so the current beat is always the low lanes.
  argmax_reduce #(
    .DATA_WIDTH  (DATA_WIDTH),
    .NUM_CLASSES (NUM_CLASSES),
    .LANES       (LANES),
    .IDX_WIDTH   (IDX_WIDTH)
  ) u_reduce (
    .lanes_i     (snap_q[LaneW-1:0]),
    .base_idx_i  (base_idx),
    .run_max_i   (run_max_q),
    .win_upd_o   (win_upd),
    .win_index_o (win_index),
    .win_value_o (win_value)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= StIdle;
      beat_q      <= '0;
      snap_q      <= '0;
      run_max_q   <= '0;
      run_idx_q   <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      max_index_q <= '0;
      max_value_q <= '0;
    end else begin
      case (state_q)
        StIdle: begin
          if (start_i) begin
            snap_q    <= SnapW'(scores_i);
            beat_q    <= '0;
            run_max_q <= MaxInit;
            run_idx_q <= '0;
            busy_q    <= 1'b1;
            state_q   <= StScan;
          end
        end
        StScan: begin
          snap_q <= snap_q >> LaneW;
          if (win_upd) begin
            run_max_q <= win_value;
            run_idx_q <= win_index;
          end
          if (beat_q == BeatW'(Nbeats - 1)) begin
            beat_q      <= '0;
            done_q      <= 1'b1;
            max_value_q <= win_upd ? win_value : run_max_q;
            max_index_q <= win_upd ? win_index : run_idx_q;
            state_q     <= StDone;
          end else begin
            beat_q <= beat_q + BeatW'(1);
          end
        end
        StDone: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= StIdle;
        end
        default: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign max_index_o = max_index_q;
  assign max_value_o = max_value_q;

endmodule

// File: tb/tb_argmax_scan.sv
// Directed self-checking bench for argmax_scan; expectations adapt to ARGMAX_SIGNED_EN.
module tb_argmax_scan;
  localparam int unsigned DW = 8;
  localparam int unsigned NC = 387;
  localparam int unsigned IW = 9;
  localparam int          NB = 97;
`ifdef ARGMAX_SIGNED_EN
  localparam bit Sgn = 1'b1;
`else
  localparam bit Sgn = 1'b0;
`endif

  logic               clk_i = 1'b0;
  logic               rst_ni;
  logic               start_i;
  logic [DW*NC-1:0]   scores_i;
  logic               busy_o;
  logic               done_o;
  logic [IW-1:0]      max_index_o;
  logic [DW-1:0]      max_value_o;

  int checks   = 0;
  int failures = 0;

  always #5 clk_i = ~clk_i;

  argmax_scan #(
    .DATA_WIDTH  (DW),
    .NUM_CLASSES (NC),
    .LANES       (4),
    .IDX_WIDTH   (IW)
  ) dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .start_i     (start_i),
    .scores_i    (scores_i),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .max_index_o (max_index_o),
    .max_value_o (max_value_o)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_all(input logic [DW-1:0] v);
    for (int k = 0; k < int'(NC); k++) scores_i[DW*k +: DW] = v;
  endtask

  task automatic set_entry(input int k, input logic [DW-1:0] v);
    scores_i[DW*k +: DW] = v;
  endtask

  // Start sampled at edge T; done must appear right after edge T+NB and drop one edge later.
  task automatic run_scan(input string tag, input int exp_idx, input int exp_val);
    int n;
    @(negedge clk_i);
    start_i = 1'b1;
    @(posedge clk_i);
    #1;
    start_i = 1'b0;
    check({tag, "_busy"}, 32'(busy_o), 32'd1);
    n = 0;
    while (!done_o && n < 200) begin
      @(posedge clk_i);
      #1;
      n++;
    end
    check({tag, "_lat"}, 32'(n), 32'(NB));
    check({tag, "_idx"}, 32'(max_index_o), 32'(exp_idx));
    check({tag, "_val"}, 32'(max_value_o), 32'(exp_val));
    @(posedge clk_i);
    #1;
    check({tag, "_done_drop"}, 32'(done_o), 32'd0);
    check({tag, "_busy_drop"}, 32'(busy_o), 32'd0);
  endtask

  initial begin
    int n;
    int first;
    int dones;
    logic [IW-1:0] got_idx;
    logic [DW-1:0] got_val;

    rst_ni   = 1'b0;
    start_i  = 1'b0;
    scores_i = '0;
    #12;
    check("rst_busy", 32'(busy_o), 32'd0);
    check("rst_done", 32'(done_o), 32'd0);
    check("rst_idx", 32'(max_index_o), 32'd0);
    check("rst_val", 32'(max_value_o), 32'd0);
    @(negedge clk_i);
    rst_ni = 1'b1;

    // Signed: 0xF0 = -16 loses to 0x10 = +16 at index 0.
    set_all(8'h10);
    set_entry(200, 8'hF0);
    run_scan("peak", Sgn ? 0 : 200, Sgn ? 8'h10 : 8'hF0);

    set_all(8'h00);
    set_entry(5, 8'hFF);
    set_entry(6, 8'hFF);
    set_entry(386, 8'hFF);
    run_scan("tie3", Sgn ? 0 : 5, Sgn ? 8'h00 : 8'hFF);

    set_all(8'h00);
    set_entry(385, 8'h80);
    set_entry(386, 8'h80);
    run_scan("tie_tail", Sgn ? 0 : 385, Sgn ? 8'h00 : 8'h80);

    set_all(8'h00);
    run_scan("zero", 0, 8'h00);

    set_entry(386, 8'h01);
    run_scan("last", 386, 8'h01);

    set_all(8'h00);
    set_entry(0, 8'h7F);
    set_entry(1, 8'h80);
    run_scan("sgn_pair", Sgn ? 0 : 1, Sgn ? 8'h7F : 8'h80);

    set_all(8'h80);
    run_scan("all80", 0, 8'h80);

    // Starts during the scan and a post-capture input change must not affect anything.
    set_all(8'h10);
    set_entry(200, 8'h7F);
    @(negedge clk_i);
    start_i = 1'b1;
    @(posedge clk_i);
    #1;
    start_i = 1'b0;
    n = 0;
    first = -1;
    dones = 0;
    got_idx = '0;
    got_val = '0;
    while (n < 150) begin
      @(posedge clk_i);
      #1;
      n++;
      if (done_o) begin
        dones++;
        if (first < 0) begin
          first   = n;
          got_idx = max_index_o;
          got_val = max_value_o;
        end
      end
      if (n == 5) begin
        set_entry(200, 8'h00);
        set_entry(7, 8'h7F);
      end
      start_i = (n == 9 || n == 49);
    end
    check("busy_lat", 32'(first), 32'(NB));
    check("busy_ndone", 32'(dones), 32'd1);
    check("busy_idx", 32'(got_idx), 32'd200);
    check("busy_val", 32'(got_val), 32'h7F);

    // Asynchronous reset mid-scan clears outputs holding a nonzero prior result.
    set_all(8'h00);
    set_entry(100, 8'h55);
    @(negedge clk_i);
    start_i = 1'b1;
    @(posedge clk_i);
    #1;
    start_i = 1'b0;
    repeat (40) @(posedge clk_i);
    #3;
    rst_ni = 1'b0;
    #1;
    check("arst_busy", 32'(busy_o), 32'd0);
    check("arst_done", 32'(done_o), 32'd0);
    check("arst_idx", 32'(max_index_o), 32'd0);
    check("arst_val", 32'(max_value_o), 32'd0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    run_scan("post_rst", 100, 8'h55);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
